// File: rtl/pulse_sched.sv
// Round-robin scheduler that merges per-source event strobes onto one CDC pulse lane,
// spacing pulses at least GAP cycles apart and holding the source ID between pulses.
module pulse_sched #(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = 2,
    parameter int GAP     = 9
) (
    input  logic               clk_a,
    input  logic               rst_a_n,
    input  logic               en,
    input  logic [NUM_SRC-1:0] req_in,
    input  logic [NUM_SRC-1:0] drop_clr,
    output logic               pulse_out,
    output logic [ID_W-1:0]    id_out,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] drop,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 pulse_q, pulse_d;
    logic [NUM_SRC-1:0]   pending_q, pending_d;
    logic [NUM_SRC-1:0]   drop_q, drop_d;

    logic                 may_fire;
    logic                 grant_vld;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      idx;
    logic [NUM_SRC-1:0]   grant;

    assign may_fire = en & ((state_q == IDLE) | ((state_q == HOLD) & (cnt_q == 8'd0)));

    // First pending source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        grant     = '0;
        if (may_fire) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                idx = ID_W'((int'(rr_ptr_q) + k) % NUM_SRC);
                if (!grant_vld && pending_q[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx;
                end
            end
        end
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // A new request always wins over the grant that would clear it.
    always_comb begin
        pending_d = req_in | (pending_q & ~grant);
        drop_d    = (req_in & pending_q & ~grant) | (drop_q & ~drop_clr);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        pulse_d  = 1'b0;
        unique case (state_q)
            IDLE: if (grant_vld) state_d = HOLD;
            HOLD: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!grant_vld) begin
                    state_d = IDLE;
                end
            end
        endcase
        if (grant_vld) begin
            pulse_d  = 1'b1;
            id_d     = grant_idx;
            cnt_d    = 8'(GAP - 1);
            rr_ptr_d = ID_W'((int'(grant_idx) + 1) % NUM_SRC);
        end
    end

    always_ff @(posedge clk_a or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            pulse_q   <= 1'b0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            pulse_q   <= pulse_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
        end
    end

    assign pulse_out = pulse_q;
    assign id_out    = id_q;
    assign pending   = pending_q;
    assign drop      = drop_q;
    assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_pulse_sched.sv
// Directed bench for pulse_sched (NUM_SRC=4, ID_W=2, GAP=9): each task drives one
// scenario and compares outputs against hand-derived expectations.
module tb_pulse_sched;

    logic       clk_a = 1'b0;
    logic       rst_a_n = 1'b0;
    logic       en = 1'b1;
    logic [3:0] req_in = '0;
    logic [3:0] drop_clr = '0;
    logic       pulse_out;
    logic [1:0] id_out;
    logic [3:0] pending;
    logic [3:0] drop;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int         pulse_t[$];
    logic [1:0] pulse_id[$];

    pulse_sched #(.NUM_SRC(4), .ID_W(2), .GAP(9)) dut (
        .clk_a    (clk_a),
        .rst_a_n  (rst_a_n),
        .en       (en),
        .req_in   (req_in),
        .drop_clr (drop_clr),
        .pulse_out(pulse_out),
        .id_out   (id_out),
        .pending  (pending),
        .drop     (drop),
        .busy     (busy)
    );

    always #5 clk_a = ~clk_a;

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk_a);
        #1;
    endtask

    task automatic do_reset();
        rst_a_n  = 1'b0;
        req_in   = '0;
        drop_clr = '0;
        en       = 1'b1;
        step();
        step();
        rst_a_n = 1'b1;
    endtask

    // Records the cycle offset and ID of every pulse seen over n edges.
    task automatic watch(input int n);
        pulse_t.delete();
        pulse_id.delete();
        for (int c = 1; c <= n; c++) begin
            step();
            if (pulse_out === 1'b1) begin
                pulse_t.push_back(c);
                pulse_id.push_back(id_out);
            end
        end
    endtask

    task automatic test_reset();
        rst_a_n = 1'b0;
        #2;
        checks++;
        if ({pulse_out, id_out, pending, drop, busy} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0", {pulse_out, id_out, pending, drop, busy});
        end
        do_reset();
        checks++;
        if ({pulse_out, id_out, pending, drop, busy} !== 12'd0) begin
            failures++;
            $display("FAIL reset_release: got %b expected 0", {pulse_out, id_out, pending, drop, busy});
        end
    endtask

    task automatic test_single_event();
        int busy_cycles;
        do_reset();
        req_in = 4'b0100;
        step();
        req_in = '0;
        checks++;
        if (pending !== 4'b0100 || pulse_out !== 1'b0) begin
            failures++;
            $display("FAIL single_capture: pending=%b pulse=%b expected pending=0100 pulse=0", pending, pulse_out);
        end
        step();
        checks++;
        if (pulse_out !== 1'b1 || id_out !== 2'd2 || busy !== 1'b1 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL single_fire: pulse=%b id=%0d busy=%b pending=%b expected 1 2 1 0000",
                     pulse_out, id_out, busy, pending);
        end
        busy_cycles = 1;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (pulse_out !== 1'b0) begin
                failures++;
                $display("FAIL single_one_cycle: pulse=%b at +%0d expected 0", pulse_out, c + 1);
            end
            if (busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles !== 9) begin
            failures++;
            $display("FAIL single_busy_len: got %0d expected 9", busy_cycles);
        end
        checks++;
        if (id_out !== 2'd2) begin
            failures++;
            $display("FAIL single_id_hold: got %0d expected 2", id_out);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_in = 4'b1111;
        step();
        req_in = '0;
        watch(45);
        checks++;
        if (pulse_t.size() !== 4) begin
            failures++;
            $display("FAIL rr_count: got %0d expected 4", pulse_t.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pulse_t[i] !== 1 + 9 * i || pulse_id[i] !== 2'(i)) begin
                    failures++;
                    $display("FAIL rr_pulse%0d: t=%0d id=%0d expected t=%0d id=%0d",
                             i, pulse_t[i], pulse_id[i], 1 + 9 * i, i);
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL rr_idle: busy=%b pending=%b expected 0 0000", busy, pending);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        req_in = 4'b0001;
        step();
        req_in = '0;
        step();
        req_in = 4'b0010;
        step();
        req_in = '0;
        step();
        req_in = 4'b0010;
        step();
        req_in = '0;
        checks++;
        if (drop !== 4'b0010 || pending !== 4'b0010) begin
            failures++;
            $display("FAIL ovf_drop_set: drop=%b pending=%b expected 0010 0010", drop, pending);
        end
        watch(25);
        checks++;
        if (pulse_t.size() !== 1) begin
            failures++;
            $display("FAIL ovf_count: got %0d expected 1", pulse_t.size());
        end else begin
            checks++;
            if (pulse_t[0] !== 6 || pulse_id[0] !== 2'd1) begin
                failures++;
                $display("FAIL ovf_pulse: t=%0d id=%0d expected t=6 id=1", pulse_t[0], pulse_id[0]);
            end
        end
        checks++;
        if (drop !== 4'b0010) begin
            failures++;
            $display("FAIL ovf_drop_sticky: got %b expected 0010", drop);
        end
        drop_clr = 4'b0010;
        step();
        drop_clr = '0;
        checks++;
        if (drop !== 4'b0000) begin
            failures++;
            $display("FAIL ovf_drop_clr: got %b expected 0000", drop);
        end
    endtask

    task automatic test_collision();
        do_reset();
        req_in = 4'b1000;
        step();
        step();
        req_in = '0;
        checks++;
        if (pulse_out !== 1'b1 || id_out !== 2'd3 || pending !== 4'b1000 || drop !== 4'b0000) begin
            failures++;
            $display("FAIL coll_first: pulse=%b id=%0d pending=%b drop=%b expected 1 3 1000 0000",
                     pulse_out, id_out, pending, drop);
        end
        watch(20);
        checks++;
        if (pulse_t.size() !== 1) begin
            failures++;
            $display("FAIL coll_count: got %0d expected 1", pulse_t.size());
        end else begin
            checks++;
            if (pulse_t[0] !== 9 || pulse_id[0] !== 2'd3) begin
                failures++;
                $display("FAIL coll_second: t=%0d id=%0d expected t=9 id=3", pulse_t[0], pulse_id[0]);
            end
        end
        checks++;
        if (pending !== 4'b0000 || drop !== 4'b0000) begin
            failures++;
            $display("FAIL coll_end: pending=%b drop=%b expected 0000 0000", pending, drop);
        end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0;
        req_in = 4'b0011;
        step();
        req_in = '0;
        watch(6);
        checks++;
        if (pulse_t.size() !== 0 || pending !== 4'b0011 || busy !== 1'b0) begin
            failures++;
            $display("FAIL en_gated: pulses=%0d pending=%b busy=%b expected 0 0011 0",
                     pulse_t.size(), pending, busy);
        end
        en = 1'b1;
        watch(20);
        checks++;
        if (pulse_t.size() !== 2) begin
            failures++;
            $display("FAIL en_count: got %0d expected 2", pulse_t.size());
        end else begin
            checks++;
            if (pulse_t[0] !== 1 || pulse_id[0] !== 2'd0 || pulse_t[1] !== 10 || pulse_id[1] !== 2'd1) begin
                failures++;
                $display("FAIL en_pulses: t0=%0d id0=%0d t1=%0d id1=%0d expected 1 0 10 1",
                         pulse_t[0], pulse_id[0], pulse_t[1], pulse_id[1]);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req_in = 4'b1111;
        step();
        req_in = '0;
        step();
        step();
        step();
        checks++;
        if (busy !== 1'b1 || pending !== 4'b1110) begin
            failures++;
            $display("FAIL midrst_pre: busy=%b pending=%b expected 1 1110", busy, pending);
        end
        #2;
        rst_a_n = 1'b0;
        #1;
        checks++;
        if ({pulse_out, id_out, pending, drop, busy} !== 12'd0) begin
            failures++;
            $display("FAIL midrst_async: got %b expected 0", {pulse_out, id_out, pending, drop, busy});
        end
        step();
        rst_a_n = 1'b1;
        watch(40);
        checks++;
        if (pulse_t.size() !== 0 || pending !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after: pulses=%0d pending=%b busy=%b expected 0 0000 0",
                     pulse_t.size(), pending, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_round_robin();
        test_overflow();
        test_collision();
        test_enable();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
